// File: rtl/cdb_grant_scheduler.sv
// cdb_grant_scheduler: gives the two CDB broadcast lanes to the 20 FU result ports.
// Each lane grants at most one FU per cycle. The FU is picked in three steps:
// fixed category priority (BEQ > MULT > LS > ALU), then round-robin inside the
// category, then optional starvation aging.
// Define CDB_AGING_EN to build the per-category age counters. A category that
// has been passed over AGE_MAX cycles in a row is then promoted above the fixed
// priority. Without the macro, the fixed priority is strict and ALU can starve.
// Grants are combinational from the current valids, so an FU is granted in the
// same cycle it raises valid.
module cdb_grant_scheduler #(
  parameter int NUM_FU  = 20,
  parameter int AGE_MAX = 7,
  parameter int AGE_W   = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_FU-1:0] fu_result_valid,
  input  logic [1:0]        cdb_stall,
  output logic [NUM_FU-1:0] fu_grant,
  output logic [1:0]        lane_valid,
  output logic [4:0]        lane_fu_num_0,
  output logic [4:0]        lane_fu_num_1,
  output logic [3:0]        lane_cat_0,
  output logic [3:0]        lane_cat_1
);

  localparam int NUM_LANES = 2;

`ifdef CDB_AGING_EN
  localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(AGE_MAX);
`endif

  // Per-lane results, merged into the shared outputs at the bottom.
  logic [NUM_FU-1:0] lane_grant [NUM_LANES];
  logic              lane_vld   [NUM_LANES];
  logic [4:0]        lane_num   [NUM_LANES];
  logic [3:0]        lane_cat   [NUM_LANES];

  // Return the first requesting slot at or after ptr, wrapping around a
  // 4-entry category.
  function automatic logic [1:0] pick4(input logic [3:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic       found;
    pick4 = ptr;
    found = 1'b0;
    for (int j = 0; j < 4; j++) begin
      idx = ptr + 2'(j);
      if (!found && req[idx]) begin
        pick4 = idx;
        found = 1'b1;
      end
    end
  endfunction

  // Same scan for a 2-entry category.
  function automatic logic pick2(input logic [1:0] req, input logic ptr);
    pick2 = req[ptr] ? ptr : ~ptr;
  endfunction

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    // Each category occupies every other FU number, starting at a lane-specific base.
    localparam int BASE_ALU  = (gi == 0) ? 0  : 1;
    localparam int BASE_LS   = (gi == 0) ? 9  : 8;
    localparam int BASE_MULT = (gi == 0) ? 12 : 13;
    localparam int BASE_BEQ  = (gi == 0) ? 17 : 16;
    // Value driven on lane_fu_num_<lane> when the lane is idle.
    localparam int IDLE_NUM  = (gi == 0) ? 0  : 1;

    logic [3:0] alu_req;
    logic [1:0] ls_req;
    logic [1:0] mult_req;
    logic [1:0] beq_req;
    logic [3:0] cat_req;
    logic [3:0] cat_aged;
    logic [3:0] cat_pool;
    logic [3:0] cat_sel;
    logic [1:0] alu_idx;
    logic       ls_idx;
    logic       mult_idx;
    logic       beq_idx;
    logic       granted;
    logic [4:0] fu_num;
    logic [1:0] alu_ptr_q;
    logic [1:0] alu_ptr_d;
    logic       ls_ptr_q;
    logic       ls_ptr_d;
    logic       mult_ptr_q;
    logic       mult_ptr_d;
    logic       beq_ptr_q;
    logic       beq_ptr_d;

    for (genvar ki = 0; ki < 4; ki++) begin : g_alu_req
      assign alu_req[ki] = fu_result_valid[BASE_ALU + 2*ki];
    end

    for (genvar ki = 0; ki < 2; ki++) begin : g_pair_req
      assign ls_req[ki]   = fu_result_valid[BASE_LS   + 2*ki];
      assign mult_req[ki] = fu_result_valid[BASE_MULT + 2*ki];
      assign beq_req[ki]  = fu_result_valid[BASE_BEQ  + 2*ki];
    end

    // Bit order matches lane_cat: bit3 BEQ, bit2 MULT, bit1 LS, bit0 ALU.
    assign cat_req = {|beq_req, |mult_req, |ls_req, |alu_req};

`ifdef CDB_AGING_EN
    logic [AGE_W-1:0] age_q [4];
    logic [AGE_W-1:0] age_d [4];

    for (genvar ci = 0; ci < 4; ci++) begin : g_aged
      assign cat_aged[ci] = cat_req[ci] && (age_q[ci] == AGE_LIM);
    end

    // Age counters: cleared when the category is served or goes idle, otherwise saturating count.
    always_comb begin
      for (int c = 0; c < 4; c++) begin
        age_d[c] = '0;
        if (cat_req[c] && !(granted && cat_sel[c])) begin
          age_d[c] = (age_q[c] == AGE_LIM) ? age_q[c] : age_q[c] + AGE_W'(1);
        end
      end
    end

    // Age register, cleared by reset.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        for (int c = 0; c < 4; c++) begin
          age_q[c] <= '0;
        end
      end else begin
        for (int c = 0; c < 4; c++) begin
          age_q[c] <= age_d[c];
        end
      end
    end
`else
    assign cat_aged = 4'b0000;
`endif

    // Category select: aged categories outrank everything, then fixed priority BEQ > MULT > LS > ALU.
    always_comb begin
      cat_pool = (cat_aged != 4'b0000) ? cat_aged : cat_req;
      cat_sel  = 4'b0000;
      if (cat_pool[3]) begin
        cat_sel = 4'b1000;
      end else if (cat_pool[2]) begin
        cat_sel = 4'b0100;
      end else if (cat_pool[1]) begin
        cat_sel = 4'b0010;
      end else if (cat_pool[0]) begin
        cat_sel = 4'b0001;
      end
    end

    assign alu_idx  = pick4(alu_req, alu_ptr_q);
    assign ls_idx   = pick2(ls_req, ls_ptr_q);
    assign mult_idx = pick2(mult_req, mult_ptr_q);
    assign beq_idx  = pick2(beq_req, beq_ptr_q);

    // A stalled lane still arbitrates so that its categories keep aging, but it issues no grant.
    assign granted = !reset && !cdb_stall[gi] && (cat_req != 4'b0000);

    // Map the chosen category and slot back to a global FU number.
    always_comb begin
      fu_num = 5'(BASE_ALU) + {2'b00, alu_idx, 1'b0};
      if (cat_sel[3]) begin
        fu_num = 5'(BASE_BEQ) + {3'b000, beq_idx, 1'b0};
      end else if (cat_sel[2]) begin
        fu_num = 5'(BASE_MULT) + {3'b000, mult_idx, 1'b0};
      end else if (cat_sel[1]) begin
        fu_num = 5'(BASE_LS) + {3'b000, ls_idx, 1'b0};
      end
    end

    assign lane_grant[gi] = granted ? (NUM_FU'(1) << fu_num) : '0;
    assign lane_vld[gi]   = granted;
    assign lane_num[gi]   = granted ? fu_num : 5'(IDLE_NUM);
    assign lane_cat[gi]   = granted ? cat_sel : 4'b0000;

    // Round-robin pointers: advance past the winner of the served category only.
    always_comb begin
      alu_ptr_d  = alu_ptr_q;
      ls_ptr_d   = ls_ptr_q;
      mult_ptr_d = mult_ptr_q;
      beq_ptr_d  = beq_ptr_q;
      if (granted) begin
        if (cat_sel[0]) alu_ptr_d  = alu_idx + 2'd1;
        if (cat_sel[1]) ls_ptr_d   = ~ls_idx;
        if (cat_sel[2]) mult_ptr_d = ~mult_idx;
        if (cat_sel[3]) beq_ptr_d  = ~beq_idx;
      end
    end

    // Pointer register, returned to slot 0 by reset.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        alu_ptr_q  <= 2'd0;
        ls_ptr_q   <= 1'b0;
        mult_ptr_q <= 1'b0;
        beq_ptr_q  <= 1'b0;
      end else begin
        alu_ptr_q  <= alu_ptr_d;
        ls_ptr_q   <= ls_ptr_d;
        mult_ptr_q <= mult_ptr_d;
        beq_ptr_q  <= beq_ptr_d;
      end
    end
  end

  // Lanes cover disjoint FU sets, so OR-ing their grants cannot collide.
  assign fu_grant      = lane_grant[0] | lane_grant[1];
  assign lane_valid    = {lane_vld[1], lane_vld[0]};
  assign lane_fu_num_0 = lane_num[0];
  assign lane_fu_num_1 = lane_num[1];
  assign lane_cat_0    = lane_cat[0];
  assign lane_cat_1    = lane_cat[1];

endmodule

// File: tb/tb_cdb_grant_scheduler.sv
// Testbench for cdb_grant_scheduler: directed scenarios followed by a
// randomized run. Every cycle is compared against a behavioural model built
// from FU lists, round-robin pointers and age counters.
// The model follows CDB_AGING_EN in the same way the design does.
module tb_cdb_grant_scheduler;

  localparam int AGE_MAX = 7;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] fu_result_valid = '0;
  logic [1:0]  cdb_stall = '0;
  logic [19:0] fu_grant;
  logic [1:0]  lane_valid;
  logic [4:0]  lane_fu_num_0;
  logic [4:0]  lane_fu_num_1;
  logic [3:0]  lane_cat_0;
  logic [3:0]  lane_cat_1;

  cdb_grant_scheduler dut (
    .clock           (clock),
    .reset           (reset),
    .fu_result_valid (fu_result_valid),
    .cdb_stall       (cdb_stall),
    .fu_grant        (fu_grant),
    .lane_valid      (lane_valid),
    .lane_fu_num_0   (lane_fu_num_0),
    .lane_fu_num_1   (lane_fu_num_1),
    .lane_cat_0      (lane_cat_0),
    .lane_cat_1      (lane_cat_1)
  );

  always #5 clock = ~clock;

  // FU membership per lane and category (0 ALU, 1 LS, 2 MULT, 3 BEQ), in round-robin order.
  int fu_tab [2][4][4] = '{
    '{'{0, 2, 4, 6}, '{9, 11, 0, 0}, '{12, 14, 0, 0}, '{17, 19, 0, 0}},
    '{'{1, 3, 5, 7}, '{8, 10, 0, 0}, '{13, 15, 0, 0}, '{16, 18, 0, 0}}
  };
  int cat_size [4] = '{4, 2, 2, 2};

  int m_ptr [2][4];
  int m_age [2][4];
  bit m_req [2][4];
  int sel_cat [2];
  int sel_idx [2];

  logic [19:0] exp_grant;
  logic [1:0]  exp_lv;
  logic [4:0]  exp_num [2];
  logic [3:0]  exp_cat [2];

  logic [19:0] obs_grant;
  logic [1:0]  obs_lv;
  logic [4:0]  obs_num0;
  logic [4:0]  obs_num1;
  logic [3:0]  obs_cat0;
  logic [3:0]  obs_cat1;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < 4; c++) begin
        m_ptr[l][c] = 0;
        m_age[l][c] = 0;
      end
    end
  endfunction

  function automatic void model_eval(input logic [19:0] v, input logic [1:0] s, input logic rst);
    int f;
    exp_grant  = '0;
    exp_lv     = '0;
    exp_num[0] = 5'd0;
    exp_num[1] = 5'd1;
    exp_cat[0] = 4'd0;
    exp_cat[1] = 4'd0;
    for (int l = 0; l < 2; l++) begin
      sel_cat[l] = -1;
      sel_idx[l] = -1;
      for (int c = 0; c < 4; c++) begin
        m_req[l][c] = 1'b0;
        for (int k = 0; k < cat_size[c]; k++) begin
          if (v[fu_tab[l][c][k]]) m_req[l][c] = 1'b1;
        end
      end
`ifdef CDB_AGING_EN
      for (int c = 3; c >= 0; c--) begin
        if (sel_cat[l] < 0 && m_req[l][c] && m_age[l][c] == AGE_MAX) sel_cat[l] = c;
      end
`endif
      for (int c = 3; c >= 0; c--) begin
        if (sel_cat[l] < 0 && m_req[l][c]) sel_cat[l] = c;
      end
      if (!rst && sel_cat[l] >= 0 && !s[l]) begin
        for (int j = 0; j < cat_size[sel_cat[l]]; j++) begin
          int k;
          k = (m_ptr[l][sel_cat[l]] + j) % cat_size[sel_cat[l]];
          if (sel_idx[l] < 0 && v[fu_tab[l][sel_cat[l]][k]]) sel_idx[l] = k;
        end
        f = fu_tab[l][sel_cat[l]][sel_idx[l]];
        exp_grant[f] = 1'b1;
        exp_lv[l]    = 1'b1;
        exp_num[l]   = 5'(f);
        exp_cat[l]   = 4'(1 << sel_cat[l]);
      end
    end
  endfunction

  function automatic void model_update();
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < 4; c++) begin
        if (exp_lv[l] && sel_cat[l] == c) begin
          m_ptr[l][c] = (sel_idx[l] + 1) % cat_size[c];
          m_age[l][c] = 0;
        end else if (m_req[l][c]) begin
          m_age[l][c] = (m_age[l][c] < AGE_MAX) ? m_age[l][c] + 1 : AGE_MAX;
        end else begin
          m_age[l][c] = 0;
        end
      end
    end
  endfunction

  // Drive this cycle's inputs, compare all outputs against the model, then advance one edge.
  task automatic apply(input logic [19:0] v, input logic [1:0] s);
    fu_result_valid = v;
    cdb_stall       = s;
    #1;
    model_eval(v, s, reset);
    obs_grant = fu_grant;
    obs_lv    = lane_valid;
    obs_num0  = lane_fu_num_0;
    obs_num1  = lane_fu_num_1;
    obs_cat0  = lane_cat_0;
    obs_cat1  = lane_cat_1;
    check("model_grant", obs_grant, exp_grant);
    check("model_lane_valid", obs_lv, exp_lv);
    check("model_num0", obs_num0, exp_num[0]);
    check("model_num1", obs_num1, exp_num[1]);
    check("model_cat0", obs_cat0, exp_cat[0]);
    check("model_cat1", obs_cat1, exp_cat[1]);
    $display("cyc %0d valid=%05h stall=%b grant=%05h lanes=%b num0=%0d num1=%0d cat0=%b cat1=%b",
             cyc, v, s, obs_grant, obs_lv, obs_num0, obs_num1, obs_cat0, obs_cat1);
    cyc++;
    @(posedge clock);
    if (!reset) model_update();
  endtask

  task automatic step(input logic [19:0] v, input logic [1:0] s);
    @(negedge clock);
    apply(v, s);
  endtask

  // Hold reset for a cycle with every valid high and check that all outputs are idle.
  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    fu_result_valid = '1;
    cdb_stall = 2'b00;
    #1;
    check("rst_grant", fu_grant, 20'h0);
    check("rst_lane_valid", lane_valid, 2'b00);
    check("rst_num0", lane_fu_num_0, 5'd0);
    check("rst_num1", lane_fu_num_1, 5'd1);
    check("rst_cat0", lane_cat_0, 4'b0000);
    check("rst_cat1", lane_cat_1, 4'b0000);
    $display("reset applied");
    @(negedge clock);
    reset = 1'b0;
    fu_result_valid = '0;
    model_reset();
  endtask

  initial begin
    logic [19:0] v;
    logic [19:0] burst_exp [5];
    int first_alu;
    logic [1:0] s;

    // Single FU0 request after reset; the pointer then moves past FU0.
    do_reset();
    step(20'h00001, 2'b00);
    check("fu0_grant", obs_grant, 20'h00001);
    check("fu0_lane_valid", obs_lv, 2'b01);
    check("fu0_num0", obs_num0, 5'd0);
    check("fu0_cat0", obs_cat0, 4'b0001);
    step(20'h00005, 2'b00);
    check("ptr_after_fu0", obs_grant, 20'h00004);

    // ALU burst on lane 0; each FU drops its valid after its grant.
    do_reset();
    burst_exp = '{20'h00001, 20'h00004, 20'h00010, 20'h00040, 20'h00000};
    v = 20'h00055;
    for (int i = 0; i < 5; i++) begin
      step(v, 2'b00);
      check($sformatf("burst_%0d", i), obs_grant, burst_exp[i]);
      v = v & ~burst_exp[i];
    end

    // BEQ outranks ALU.
    do_reset();
    step(20'h20001, 2'b00);
    check("beq_first_grant", obs_grant, 20'h20000);
    check("beq_first_cat0", obs_cat0, 4'b1000);
    step(20'h00001, 2'b00);
    check("alu_next_grant", obs_grant, 20'h00001);
    check("alu_next_cat0", obs_cat0, 4'b0001);

    // FU0 against a continuous BEQ stream.
    do_reset();
    first_alu = 0;
    for (int c = 1; c <= 10; c++) begin
      step(20'hA0001, 2'b00);
      if (obs_grant[0] && first_alu == 0) first_alu = c;
    end
`ifdef CDB_AGING_EN
    check("aging_fu0_cycle", first_alu, 8);
`else
    check("no_aging_fu0_never", first_alu, 0);
`endif

    // A stalled lane 0 suppresses FU0; FU1 is still granted on lane 1.
    do_reset();
    step(20'h00003, 2'b01);
    check("stall_grant", obs_grant, 20'h00002);
    check("stall_lane_valid", obs_lv, 2'b10);
    check("stall_num1", obs_num1, 5'd1);
    check("stall_cat0", obs_cat0, 4'b0000);
    step(20'h00001, 2'b00);
    check("unstall_grant", obs_grant, 20'h00001);

    // Asynchronous reset mid-cycle while lane 0 grants FU2; afterwards FU0 wins again.
    do_reset();
    step(20'h00005, 2'b00);
    check("pre_rst_first", obs_grant, 20'h00001);
    @(negedge clock);
    fu_result_valid = 20'h00005;
    #1;
    check("pre_rst_grant", fu_grant, 20'h00004);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_grant", fu_grant, 20'h00000);
    check("async_rst_lane_valid", lane_valid, 2'b00);
    check("async_rst_num1", lane_fu_num_1, 5'd1);
    $display("async reset asserted mid-cycle");
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    apply(20'h00005, 2'b00);
    check("post_rst_grant", obs_grant, 20'h00001);

    // Randomized traffic: FUs hold valid until granted, lanes stall at random.
    do_reset();
    v = '0;
    for (int i = 0; i < 600; i++) begin
      v = v | (20'($urandom) & 20'($urandom) & 20'($urandom));
      s[0] = ($urandom_range(0, 4) == 0);
      s[1] = ($urandom_range(0, 4) == 0);
      step(v, s);
      v = v & ~exp_grant;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cdb_grant_scheduler.md
Name: cdb_grant_scheduler

Overview:
Sequential arbiter that shares the two CDB broadcast lanes among the 20 functional-unit result ports. Each cycle it grants at most one FU per lane. Selection uses fixed category priority, per-category round-robin within a lane, and starvation aging. It sits between the FU result registers and the CDB drivers. An FU holds its result valid until it sees its grant bit.

Parameters:
NUM_FU, 20, number of FU result ports (fixed partition below)
AGE_MAX, 7, unserved-cycle count at which a category is promoted
AGE_W, 3, width of each age counter; must hold AGE_MAX

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
fu_result_valid  input  20  per-FU result ready, held until granted
cdb_stall  input  2  per-lane: lane cannot accept a broadcast this cycle
fu_grant  output  20  per-FU grant; FU drops/advances its result on the next edge
lane_valid  output  2  lane l broadcasts this cycle
lane_fu_num_0  output  5  FU index granted on lane 0 (0 when lane_valid[0]=0)
lane_fu_num_1  output  5  FU index granted on lane 1 (1 when lane_valid[1]=0)
lane_cat_0  output  4  one-hot category on lane 0: bit3 BEQ, bit2 MULT, bit1 LS, bit0 ALU
lane_cat_1  output  4  same encoding for lane 1

Behaviour:
- Clock and reset: one clock, `clock`. `reset` is asynchronous and active-high.
- Lane partition is fixed.
  - Lane 0 serves ALU {0,2,4,6}, LS {9,11}, MULT {12,14}, BEQ {17,19}.
  - Lane 1 serves ALU {1,3,5,7}, LS {8,10}, MULT {13,15}, BEQ {16,18}.
  - Round-robin index k within a category follows the listed order.
- Grants are combinational from fu_result_valid and registered state, so there is zero-cycle latency. State updates on the rising clock edge.
- State per lane per category:
  - rr pointer: 2 bits for ALU, 1 bit for the others.
  - age counter: AGE_W bits.
- Category select, per lane:
  - A category is "requesting" if any of its FUs in that lane has valid.
  - A category is "aged" if requesting and age == AGE_MAX.
  - If any category is aged, pick the highest-priority aged one. Otherwise pick the highest-priority requesting one.
  - Priority order: BEQ > MULT > LS > ALU.
- Unit select: inside the chosen category, the first requesting index at or after the rr pointer, scanning cyclically.
- Grant is suppressed on lane l when cdb_stall[l]=1. In that case lane_valid[l]=0, no fu_grant bits are set for lane l, and lane_cat_l=0.
- Edge update, granted category on a granted lane:
  - rr pointer becomes (granted index + 1) mod category size.
  - age becomes 0.
- Edge update, every other category:
  - Requesting and not granted (including stalled): age becomes min(age+1, AGE_MAX); it saturates.
  - Not requesting: age becomes 0.
  - rr pointer holds.
- Reset (asynchronous):
  - All rr pointers and ages go to 0.
  - While reset is high, fu_grant=0, lane_valid=0, lane_cat_0/1=0, lane_fu_num_0=0, lane_fu_num_1=1.
  - Reset asserted mid-burst drops pending arbitration history. Held FU valids re-arbitrate from pointer 0 after release.
- Boundaries:
  - All valids low: both lanes idle and all ages are 0.
  - Both lanes select independently and may grant in the same cycle.
  - At most 2 fu_grant bits are high, at most one per lane.
  - A stalled lane still ages its requesters, so it can promote a category on the first unstalled cycle.

Optional Feature:
CDB_AGING_EN
- Defined: aging as described; age counters present.
- Undefined: no age counters; strict fixed priority BEQ > MULT > LS > ALU with rr only inside a category. In this mode ALU can starve indefinitely.

Test Plan:
- After reset, valid=20'h00001 (FU0) -> same cycle fu_grant=20'h00001, lane_valid=2'b01, lane_fu_num_0=0, lane_cat_0=4'b0001; lane-0 ALU ptr becomes 1.
- Valid bits 0,2,4,6 held high, FU drops valid one cycle after its grant -> lane-0 grants FU 0,2,4,6 on consecutive cycles; then lane idle.
- Valid = FU17 and FU0 simultaneously -> FU17 granted first with lane_cat_0=4'b1000; FU0 granted the next cycle.
- Aging (CDB_AGING_EN defined):
  - Stimulus: FU0 held high; BEQ FU17/19 re-asserted every cycle for 10 cycles.
  - Response: FU0 granted on cycle 8 (age reaches 7 after 7 losses).
  - Without the macro: FU0 is never granted during the BEQ stream.
- cdb_stall=2'b01 with FU0 and FU1 valid -> only FU1 granted (lane_fu_num_1=1); lane-0 ALU age=1 after the edge; FU0 granted on the first unstalled cycle.
- Reset asserted asynchronously mid-cycle while lane 0 is granting -> fu_grant=0 immediately; after release, rr pointers are 0 (FU0 wins over FU2).
